// File: rtl/mips_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_pkg
// Description : Shared encodings for the MIPS execute-unit ALU: opcode and
//               funct values, flag bit positions and the signed-overflow
//               helper used by every adding instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_alu_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // Flag bit positions
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

    // Signed overflow of a + b = s: operands agree in sign, sum disagrees.
    function automatic logic add_ovf(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_core
// Description : Purely combinational decode and compute for the MIPS ALU.
//   instruction_i [31:0] : instruction word
//   rega_i        [31:0] : register operand A
//   regb_i        [31:0] : register operand B
//   result_o      [31:0] : computed result
//   flags_o       [2:0]  : {zero, negative/less, overflow}
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu_core
    import mips_alu_pkg::*;
(
    input  logic [31:0] instruction_i,
    input  logic [31:0] rega_i,
    input  logic [31:0] regb_i,
    output logic [31:0] result_o,
    output logic [2:0]  flags_o
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [31:0] w_rs;
    logic [31:0] w_rt;
    logic [31:0] w_rt_neg;
    logic        w_unused_fields;

    assign w_op    = instruction_i[31:26];
    assign w_funct = instruction_i[5:0];
    assign w_shamt = instruction_i[10:6];
    assign w_simm  = {{16{instruction_i[15]}}, instruction_i[15:0]};
    assign w_zimm  = {16'h0000, instruction_i[15:0]};

    // Only bit 0 of rs/rt chooses between the two supplied register values.
    assign w_rs = instruction_i[21] ? regb_i : rega_i;
    assign w_rt = instruction_i[16] ? regb_i : rega_i;

    // Upper register-number bits carry no meaning for this unit.
    assign w_unused_fields = ^{instruction_i[25:22], instruction_i[20:17]};

    // Subtraction is performed as RS + two's complement of RT so the
    // overflow rule is evaluated on the effective addition.
    assign w_rt_neg = ~w_rt + 32'd1;

    logic [31:0] w_res;
    logic        w_zf;
    logic        w_nf;
    logic        w_of;

    always_comb begin
        w_res = 32'd0;
        w_zf  = 1'b0;
        w_nf  = 1'b0;
        w_of  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD: begin
                        w_res = w_rs + w_rt;
                        w_of  = add_ovf(w_rs, w_rt, w_res);
                    end
                    F_ADDU: w_res = w_rs + w_rt;
                    F_SUB: begin
                        w_res = w_rs + w_rt_neg;
                        w_of  = add_ovf(w_rs, w_rt_neg, w_res);
                    end
                    F_SUBU: w_res = w_rs + w_rt_neg;
                    F_AND:  w_res = w_rs & w_rt;
                    F_OR:   w_res = w_rs | w_rt;
                    F_XOR:  w_res = w_rs ^ w_rt;
                    F_NOR:  w_res = ~(w_rs | w_rt);
                    F_SLT: begin
                        w_nf  = $signed(w_rs) < $signed(w_rt);
                        w_res = {31'd0, w_nf};
                    end
                    F_SLTU: begin
                        w_nf  = w_rs < w_rt;
                        w_res = {31'd0, w_nf};
                    end
                    F_SLL:  w_res = w_rt << w_shamt;
                    F_SRL:  w_res = w_rt >> w_shamt;
                    F_SRA:  w_res = 32'($signed(w_rt) >>> w_shamt);
                    F_SLLV: w_res = w_rt << w_rs[4:0];
                    F_SRLV: w_res = w_rt >> w_rs[4:0];
                    F_SRAV: w_res = 32'($signed(w_rt) >>> w_rs[4:0]);
                    default: ;
                endcase
            end
            OP_ADDI: begin
                w_res = w_rs + w_simm;
                w_of  = add_ovf(w_rs, w_simm, w_res);
            end
            OP_ADDIU: w_res = w_rs + w_simm;
            OP_ANDI:  w_res = w_rs & w_zimm;
            // ori deliberately uses the sign-extended immediate.
            OP_ORI:   w_res = w_rs | w_simm;
            OP_XORI:  w_res = w_rs ^ w_zimm;
            OP_SLTI: begin
                w_nf  = $signed(w_rs) < $signed(w_simm);
                w_res = {31'd0, w_nf};
            end
            OP_SLTIU: begin
                w_nf  = w_rs < w_simm;
                w_res = {31'd0, w_nf};
            end
            OP_BEQ, OP_BNE: begin
                w_res = w_rs + w_rt_neg;
                w_zf  = (w_rs == w_rt);
            end
            OP_LW, OP_SW: w_res = w_rs + w_zimm;
            default: ;
        endcase
    end

    always_comb begin
        flags_o            = 3'b000;
        flags_o[FLAG_ZERO] = w_zf;
        flags_o[FLAG_NEG]  = w_nf;
        flags_o[FLAG_OVF]  = w_of;
    end

    assign result_o = w_res;

endmodule
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu
// Description : Single-stage MIPS execute ALU with registered outputs
//               (one clock of latency, new inputs every cycle).
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset, clears outputs
//   instruction : 32-bit instruction word
//   regA, regB  : 32-bit register operands
//   result      : registered 32-bit result
//   flags       : registered {zero, negative/less, overflow}
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    logic [31:0] result_d;
    logic [2:0]  flags_d;
    logic [31:0] result_q;
    logic [2:0]  flags_q;

    mips_alu_core u_core (
        .instruction_i (instruction),
        .rega_i        (regA),
        .regb_i        (regB),
        .result_o      (result_d),
        .flags_o       (flags_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'd0;
            flags_q  <= 3'b000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_alu
// Description : Scoreboard testbench for mips_alu using directed vectors
//               with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_alu;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [31:0] result;
    logic [2:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_bad;
    logic [31:0] last_res;
    logic [2:0]  last_flg;

    mips_alu dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .regA        (regA),
        .regB        (regB),
        .result      (result),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] r,
                         input logic [2:0] f, input logic [31:0] er,
                         input logic [2:0] ef);
        n_cmp = n_cmp + 1;
        if (r !== er || f !== ef) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got result=%08h flags=%03b, want result=%08h flags=%03b",
                     name, r, f, er, ef);
        end
    endtask

    // Monitor: every clock the DUT presents a new output; compare against
    // the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, result, flags, e.res, e.flg);
            end
        end
    end

    // Called just after a falling edge: drive a vector, queue its expected
    // response, and confirm the outputs have not moved before the next edge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic [2:0] ef, input string name);
        exp_t e;
        instruction = ins;
        regA        = a;
        regB        = b;
        e.res  = er;
        e.flg  = ef;
        e.name = name;
        exp_q.push_back(e);
        #1;
        check({name, "_hold"}, result, flags, last_res, last_flg);
        last_res = er;
        last_flg = ef;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        last_res    = 32'd0;
        last_flg    = 3'b000;
        rst         = 1'b1;
        instruction = 32'd0;
        regA        = 32'd0;
        regB        = 32'd0;
        repeat (2) @(negedge clk);
        check("reset", result, flags, 32'd0, 3'b000);
        rst = 1'b0;

        // Arithmetic
        @(negedge clk); issue(32'h00010020, 32'h7fffffff, 32'h00000001, 32'h80000000, 3'b001, "add_ovf");
        @(negedge clk); issue(32'h00010022, 32'h7fffffff, 32'hffffffff, 32'h80000000, 3'b001, "sub_ovf");
        @(negedge clk); issue(32'h00010020, 32'h80000000, 32'h80000000, 32'h00000000, 3'b001, "add_negovf");
        @(negedge clk); issue(32'h00010021, 32'h80000000, 32'h80000000, 32'h00000000, 3'b000, "addu_wrap");
        @(negedge clk); issue(32'h00010023, 32'h00000005, 32'h00000007, 32'hfffffffe, 3'b000, "subu");
        // Logic
        @(negedge clk); issue(32'h00010024, 32'hf0f0ffff, 32'h0ff0f00f, 32'h00f0f00f, 3'b000, "and");
        @(negedge clk); issue(32'h00010025, 32'h00ff0000, 32'h000000ff, 32'h00ff00ff, 3'b000, "or");
        @(negedge clk); issue(32'h00010026, 32'hffff0000, 32'hff00ff00, 32'h00ffff00, 3'b000, "xor");
        @(negedge clk); issue(32'h00010027, 32'h00000000, 32'h0000ffff, 32'hffff0000, 3'b000, "nor");
        // Immediates
        @(negedge clk); issue(32'h2000fffe, 32'hffffffff, 32'h00000000, 32'hfffffffd, 3'b000, "addi");
        @(negedge clk); issue(32'h2420fff9, 32'h00000000, 32'hfffffff8, 32'hfffffff1, 3'b000, "addiu");
        @(negedge clk); issue(32'h3420ff00, 32'h00000000, 32'h0000000f, 32'hffffff0f, 3'b000, "ori_sext");
        @(negedge clk); issue(32'h3800ffff, 32'h0000001f, 32'h00000000, 32'h0000ffe0, 3'b000, "xori");
        @(negedge clk); issue(32'h3000ff0f, 32'hffffffff, 32'h00000000, 32'h0000ff0f, 3'b000, "andi");
        @(negedge clk); issue(32'h8c00fff0, 32'h0000000f, 32'h00000000, 32'h0000ffff, 3'b000, "lw");
        @(negedge clk); issue(32'hac008000, 32'h00000010, 32'h00000000, 32'h00008010, 3'b000, "sw");
        // Compares and branches
        @(negedge clk); issue(32'h0001002a, 32'hffffffff, 32'h00000000, 32'h00000001, 3'b010, "slt");
        @(negedge clk); issue(32'h0001002b, 32'hffffffff, 32'h00000000, 32'h00000000, 3'b000, "sltu");
        @(negedge clk); issue(32'h2800ffff, 32'hfffffffe, 32'h00000000, 32'h00000001, 3'b010, "slti");
        @(negedge clk); issue(32'h2c00ffff, 32'h00000000, 32'h00000000, 32'h00000001, 3'b010, "sltiu");
        @(negedge clk); issue(32'h10010000, 32'hfffffffa, 32'hfffffffa, 32'h00000000, 3'b100, "beq_eq");
        @(negedge clk); issue(32'h10010000, 32'h00000002, 32'h00000000, 32'h00000002, 3'b000, "beq_ne");
        @(negedge clk); issue(32'h14010000, 32'h00000002, 32'h00000000, 32'h00000002, 3'b000, "bne");
        // Shifts
        @(negedge clk); issue(32'h00010080, 32'h00000000, 32'h00000002, 32'h00000008, 3'b000, "sll");
        @(negedge clk); issue(32'h00010102, 32'h00000000, 32'h80000000, 32'h08000000, 3'b000, "srl");
        @(negedge clk); issue(32'h00010103, 32'h00000000, 32'h80000000, 32'hf8000000, 3'b000, "sra");
        @(negedge clk); issue(32'h00200004, 32'h00000003, 32'h00000024, 32'h00000030, 3'b000, "sllv");
        @(negedge clk); issue(32'h00200006, 32'hffffffff, 32'h00000004, 32'h0fffffff, 3'b000, "srlv");
        @(negedge clk); issue(32'h00010007, 32'h00000008, 32'hffff0000, 32'hffffff00, 3'b000, "srav");
        // Unsupported encodings
        @(negedge clk); issue(32'hfc000000, 32'h12345678, 32'h9abcdef0, 32'h00000000, 3'b000, "bad_op");
        @(negedge clk); issue(32'h00010001, 32'h12345678, 32'h9abcdef0, 32'h00000000, 3'b000, "bad_funct");

        // Mid-cycle asynchronous reset while the output is non-zero
        @(negedge clk); issue(32'h00010020, 32'h7fffffff, 32'h00000001, 32'h80000000, 3'b001, "pre_reset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", result, flags, 32'd0, 3'b000);
        @(posedge clk);
        #1;
        check("reset_held", result, flags, 32'd0, 3'b000);
        last_res = 32'd0;
        last_flg = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        issue(32'h00010022, 32'h00000009, 32'h00000004, 32'h00000005, 3'b000, "post_reset_sub");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: got %0d outstanding, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Single-stage execute-unit ALU for the pipelined MIPS CPU.
- Decodes a 32-bit MIPS instruction and selects operands from two register values (regA, regB) using the rs/rt fields.
- Computes a 32-bit result plus zero/negative/overflow flags.
- Outputs are registered: one clock of latency.

Parameters:
- none (data width fixed at 32)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- instruction  input  32  MIPS instruction word
- regA  input  32  register operand A
- regB  input  32  register operand B
- result  output  32  registered ALU result
- flags  output  3  registered flags: [2]=zero, [1]=negative/less, [0]=overflow

Behaviour:
- The interface uses one clock. Reset is asynchronous and active-high.
- rst=1 forces result=0 and flags=3'b000 immediately. Otherwise both outputs load the combinational values on each rising clk, so latency is 1 cycle.
- No handshake exists; new inputs are accepted every cycle.
- Fields:
  - op = instr[31:26], rs = [25:21], rt = [20:16], shamt = [10:6], funct = [5:0], imm = [15:0].
  - simm = sign-extended imm; zimm = zero-extended imm.
- Operand select: field bit0 = 0 selects regA, bit0 = 1 selects regB.
  - RS = value chosen by rs[0]; RT = value chosen by rt[0].
- R-type (op=000000), by funct:
  - 100000 add: RS+RT, overflow flag set on signed overflow.
  - 100001 addu: RS+RT, no overflow flag.
  - 100010 sub: RS-RT, signed overflow flag.
  - 100011 subu: RS-RT, no overflow flag.
  - 100100 and, 100101 or, 100110 xor, 100111 nor: bitwise on RS, RT.
  - 101010 slt: flags[1] = (RS <s RT); result = {31'b0, less}.
  - 101011 sltu: same as slt, but unsigned compare.
  - 000000 sll: RT << shamt.
  - 000010 srl: RT >> shamt, logical.
  - 000011 sra: RT >>> shamt, arithmetic.
  - 000100 sllv, 000110 srlv, 000111 srav: same shifts of RT by RS[4:0].
- I-type, by op:
  - 001000 addi: RS+simm, overflow flag set on signed overflow.
  - 001001 addiu: RS+simm, no overflow flag.
  - 001100 andi: RS & zimm.
  - 001101 ori: RS | simm. Sign-extended; this is intentional design behaviour.
  - 001110 xori: RS ^ zimm.
  - 001010 slti: signed RS < simm.
  - 001011 sltiu: unsigned RS < simm. Imm is sign-extended, then compared unsigned.
  - 000100 beq, 000101 bne: result = RS-RT; flags[2] = (RS == RT).
  - 100011 lw, 101011 sw: result = RS + zimm, no flags.
- Flag rules:
  - zero only for beq/bne; negative only for the slt family; overflow only for add/addi/sub.
  - All other flag bits are 0.
- Overflow: set when both operands of the effective addition have the same sign and the sum's sign differs. For sub, the effective addition is RS + (~RT+1). The wrapped 32-bit result is still output.
- Unsupported op/funct: result=0, flags=000.
- Reset asserted mid-stream clears the outputs. The first edge after reset release captures the current inputs.

Decomposition:
- Shared package mips_alu_pkg:
  - opcode localparams: OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE, OP_LW, OP_SW.
  - funct localparams.
  - flag bit index constants FLAG_ZERO=2, FLAG_NEG=1, FLAG_OVF=0.
- One natural sub-module: mips_alu_core, the purely combinational decode/compute logic. The top adds only the output register.

Test Plan:
- add 0x00010020, regA=0x7fffffff, regB=1, one clk -> result=0x80000000, flags=001. Next, sub 0x00010022 with regB=-1 -> 0x80000000, flags=001.
- Immediates:
  - addi 0x2000fffe, regA=-1 -> -3, flags 000.
  - addiu 0x2420fff9, regB=-8 -> -15.
  - ori 0x3420ff00, regB=15 -> 0xffffff0f.
  - xori 0x3800ffff, regA=31 -> 0x0000ffe0.
  - lw 0x8c00fff0, regA=15 -> 0x0000ffff.
- Compares:
  - slt 0x0001002a, regA=-1, regB=0 -> flags 010.
  - sltu 0x0001002b, same operands -> 000.
  - sltiu 0x2c00ffff, regA=0 -> 010.
  - beq 0x10010000, regA=regB=-6 -> flags 100.
  - bne 0x14010000, regA=2, regB=0 -> 000.
- Shifts:
  - sll 0x00010080, regB=2 -> 8.
  - srlv 0x00200006, regA=0xffffffff, regB=4 -> 0x0fffffff.
  - srav 0x00010007, regA=8, regB=0xffff0000 -> 0xffffff00.
- Reset: assert rst between clock edges while result≠0 -> result=0, flags=000 immediately. Deassert; next edge loads the current op.
- Unsupported op 0xfc000000 -> result 0, flags 000. Verify outputs change only on rising clk, i.e. 1-cycle latency.
